// File: rtl/lfsr_checker.sv
// Receive-side checker for the 12-bit LFSR pattern generator (x^12+x^6+x^4+x+1).
// Self-synchronises to the incoming word stream and reports lock, errors and wrap.
module lfsr_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 8,
  parameter int unsigned CNT_W      = 16,
  parameter logic [11:0] SEED       = 12'h001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [11:0]      data_in,
  input  logic             data_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             wrap_tick
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_e;

  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_COUNT);
  localparam logic [3:0]       LOSS_RUN = 4'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [11:0] lfsr_next(input logic [11:0] q);
    return {q[10:0], q[11] ^ q[5] ^ q[3] ^ q[0]};
  endfunction

  state_e           state_q, state_d;
  logic [11:0]      ref_word_q, ref_word_d;
  logic [3:0]       run_q, run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_tick_q, wrap_tick_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [11:0] expected_word;
  logic        word_match;
  logic [3:0]  run_inc;

  assign expected_word = lfsr_next(ref_word_q);
  assign word_match    = (data_in == expected_word);
  assign run_inc       = run_q + 4'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    ref_word_d  = ref_word_q;
    run_d       = run_q;
    err_pulse_d = 1'b0;
    wrap_tick_d = 1'b0;
    err_count_d = err_count_q;

    if (data_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (data_in != 12'h000) begin
            ref_word_d = data_in;
            run_d      = 4'd0;
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          if (data_in == 12'h000) begin
            run_d   = 4'd0;
            state_d = SEARCH;
          end else if (word_match) begin
            ref_word_d = data_in;
            if (run_inc == LOCK_RUN) begin
              run_d   = 4'd0;
              state_d = LOCKED;
            end else begin
              run_d = run_inc;
            end
          end else begin
            // Reseed from the received word and start counting matches afresh.
            ref_word_d = data_in;
            run_d      = 4'd0;
          end
        end
        LOCKED: begin
          // Flywheel: the reference follows the polynomial, never the received word.
          ref_word_d = expected_word;
          if (word_match) begin
            run_d       = 4'd0;
            wrap_tick_d = (data_in == SEED);
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
            if (run_inc == LOSS_RUN) begin
              run_d   = 4'd0;
              state_d = SEARCH;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clr_err) err_count_d = '0;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      ref_word_q  <= 12'h000;
      run_q       <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      wrap_tick_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      ref_word_q  <= ref_word_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      wrap_tick_q <= wrap_tick_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign wrap_tick = wrap_tick_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus a randomized stream,
// compared against a behavioural model; a CNT_W=4 instance shares the stimulus.
module tb_lfsr_checker;

  localparam int          LOCK_COUNT = 4;
  localparam int          LOSS_COUNT = 8;
  localparam logic [11:0] SEED       = 12'h001;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] data_in;
  logic        data_valid;
  logic        clr_err;

  logic        locked, err_pulse, wrap_tick;
  logic [15:0] err_count;
  logic        locked4, err_pulse4, wrap_tick4;
  logic [3:0]  err_count4;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(16), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .wrap_tick(wrap_tick)
  );

  lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(4), .SEED(SEED)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clr_err(clr_err),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .wrap_tick(wrap_tick4)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: "synced" means a reference word has been captured,
  // "locked" means LOCK_COUNT predictions in a row came true.
  bit          m_synced, m_locked;
  int          m_good, m_bad;
  logic [11:0] m_ref;
  bit          e_pulse, e_wrap;
  int          e_cnt16, e_cnt4;

  logic [11:0] gen;
  int          wraps_seen, wraps_exp;

  function automatic logic [11:0] lfsr_next(input logic [11:0] x);
    int fb;
    fb = (int'(x[11]) + int'(x[5]) + int'(x[3]) + int'(x[0])) % 2;
    return 12'((int'(x) * 2) % 4096 + fb);
  endfunction

  function automatic logic [11:0] bad_word(input logic [11:0] x);
    logic [11:0] w;
    w = x ^ (12'h001 << $urandom_range(11, 0));
    if (w == 12'h000) w = x ^ 12'h003;
    return w;
  endfunction

  function automatic logic [11:0] rand_nonzero();
    return 12'($urandom_range(4095, 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_synced = 0; m_locked = 0; m_good = 0; m_bad = 0; m_ref = 12'h000;
    e_pulse = 0; e_wrap = 0; e_cnt16 = 0; e_cnt4 = 0;
  endtask

  task automatic model_step(input bit v, input logic [11:0] d, input bit c);
    logic [11:0] nx;
    nx = lfsr_next(m_ref);
    e_pulse = 0;
    e_wrap  = 0;
    if (v) begin
      if (m_locked) begin
        if (d == nx) begin
          m_bad  = 0;
          e_wrap = (d == SEED);
        end else begin
          e_pulse = 1;
          if (e_cnt16 < 65535) e_cnt16++;
          if (e_cnt4 < 15) e_cnt4++;
          m_bad++;
          if (m_bad == LOSS_COUNT) begin
            m_locked = 0; m_synced = 0; m_bad = 0;
          end
        end
        m_ref = nx;
      end else if (!m_synced) begin
        if (d != 12'h000) begin
          m_ref = d; m_good = 0; m_synced = 1;
        end
      end else if (d == 12'h000) begin
        m_synced = 0; m_good = 0;
      end else if (d == nx) begin
        m_ref = d;
        m_good++;
        if (m_good == LOCK_COUNT) begin
          m_locked = 1; m_good = 0; m_bad = 0;
        end
      end else begin
        m_ref = d; m_good = 0;
      end
    end
    if (c) begin
      e_cnt16 = 0; e_cnt4 = 0;
    end
  endtask

  task automatic compare_all();
    check("locked",       32'(locked),     32'(m_locked));
    check("err_pulse",    32'(err_pulse),  32'(e_pulse));
    check("wrap_tick",    32'(wrap_tick),  32'(e_wrap));
    check("err_count",    32'(err_count),  32'(e_cnt16));
    check("locked_w4",    32'(locked4),    32'(m_locked));
    check("err_count_w4", 32'(err_count4), 32'(e_cnt4));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit v, input logic [11:0] d, input bit c);
    data_valid = v;
    data_in    = d;
    clr_err    = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    compare_all();
    if (wrap_tick) wraps_seen++;
    if (e_wrap) wraps_exp++;
    @(negedge clk);
  endtask

  task automatic feed(input logic [11:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic feed_gen();
    gen = lfsr_next(gen);
    feed(gen);
  endtask

  task automatic do_reset();
    reset = 1'b0; data_valid = 1'b0; data_in = 12'h000; clr_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; data_valid = 1'b0; data_in = 12'h000; clr_err = 1'b0;
    wraps_seen = 0; wraps_exp = 0;
    @(negedge clk);
    do_reset();

    // Lock on the start of the sequence.
    gen = SEED;
    feed(gen);
    repeat (LOCK_COUNT) feed_gen();
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_err_count", 32'(err_count), 32'd0);

    // One full period: SEED comes round exactly once.
    wraps_seen = 0; wraps_exp = 0;
    repeat (4095) feed_gen();
    check("t2_wraps", 32'(wraps_seen), 32'(wraps_exp));
    check("t2_err_count", 32'(err_count), 32'd0);

    // Single corrupted word, flywheel carries on.
    gen = lfsr_next(gen);
    feed(gen ^ 12'h001);
    check("t3_pulse", 32'(err_pulse), 32'd1);
    feed_gen();
    check("t3_no_pulse", 32'(err_pulse), 32'd0);
    check("t3_locked", 32'(locked), 32'd1);

    // LOSS_COUNT consecutive errors drop lock, a fresh stream relocks.
    repeat (LOSS_COUNT) begin
      gen = lfsr_next(gen);
      feed(bad_word(gen));
    end
    check("t4_unlocked", 32'(locked), 32'd0);
    gen = rand_nonzero();
    feed(gen);
    repeat (LOCK_COUNT) feed_gen();
    check("t4_relocked", 32'(locked), 32'd1);

    // Zero words in SEARCH, then a VERIFY reseed after two matches.
    do_reset();
    feed(12'h000);
    feed(12'h000);
    gen = rand_nonzero();
    feed(gen);
    repeat (2) feed_gen();
    gen = bad_word(lfsr_next(gen));
    feed(gen);
    repeat (LOCK_COUNT - 1) feed_gen();
    check("t5_not_yet", 32'(locked), 32'd0);
    feed_gen();
    check("t5_locked", 32'(locked), 32'd1);

    // Saturation of the narrow counter, kept locked by interleaving matches.
    repeat (20) begin
      gen = lfsr_next(gen);
      feed(bad_word(gen));
      feed_gen();
    end
    check("t6_sat_w4", 32'(err_count4), 32'hF);
    gen = lfsr_next(gen);
    step(1'b1, bad_word(gen), 1'b1);
    check("t6_clr_prio", 32'(err_count), 32'd0);
    gen = lfsr_next(gen);
    feed(bad_word(gen));
    check("t6_after_clr", 32'(err_count4), 32'd1);
    feed_gen();

    // Asynchronous reset in the middle of a cycle while locked.
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    // Randomized stream with gaps, corruption, zero words and clears.
    gen = rand_nonzero();
    for (int i = 0; i < 600; i++) begin
      bit          v, c;
      logic [11:0] d;
      int          r;
      v = ($urandom_range(99, 0) < 80);
      c = ($urandom_range(99, 0) < 4);
      d = 12'h000;
      if (v) begin
        gen = lfsr_next(gen);
        r = $urandom_range(99, 0);
        if (r < 3) d = 12'h000;
        else if (r < 15) d = bad_word(gen);
        else d = gen;
      end
      step(v, d, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
